// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants for the FIFO stream reader and its output skid buffer.
package fifo_stream_reader_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 8;
  localparam int unsigned SKID_DEPTH         = 2;
  localparam int unsigned OCC_WIDTH          = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_skid_buffer.sv
// Two-entry in-order buffer: push writes behind the head, pop shifts entry 1 to the head.
module fifo_skid_buffer
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [OCC_WIDTH-1:0]  occ,
  output logic [DATA_WIDTH-1:0] head
);

  logic [OCC_WIDTH-1:0]  occ_q, occ_d;
  logic [DATA_WIDTH-1:0] entry0_q, entry0_d;
  logic [DATA_WIDTH-1:0] entry1_q, entry1_d;

  always_comb begin
    occ_d    = occ_q;
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    unique case ({push, pop})
      2'b10: begin
        occ_d = occ_q + OCC_WIDTH'(1);
        if (occ_q == '0) begin
          entry0_d = push_data;
        end else begin
          entry1_d = push_data;
        end
      end
      2'b01: begin
        occ_d    = occ_q - OCC_WIDTH'(1);
        entry0_d = entry1_q;
        entry1_d = '0;
      end
      2'b11: begin
        // Occupancy holds; the new word lands directly behind whatever becomes the head.
        if (occ_q == OCC_WIDTH'(1)) begin
          entry0_d = push_data;
        end else begin
          entry0_d = entry1_q;
          entry1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ_q    <= '0;
      entry0_q <= '0;
      entry1_q <= '0;
    end else begin
      occ_q    <= occ_d;
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
    end
  end

  assign occ  = occ_q;
  assign head = entry0_q;

  assert property (@(posedge clock) disable iff (reset)
                   !(push && !pop && occ_q == OCC_WIDTH'(SKID_DEPTH)))
    else $error("skid buffer overflow: capture into a full buffer");

  assert property (@(posedge clock) disable iff (reset) !(pop && occ_q == '0))
    else $error("skid buffer underflow: pop from an empty buffer");

endmodule

// File: rtl/fifo_stream_reader.sv
// Issues FIFO reads, absorbs the one-cycle read latency and streams words out with backpressure.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEFAULT,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  output logic                   fifo_read_enable,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_data_in,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] word_count
);

  logic                   pending_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [OCC_WIDTH-1:0]   occ;
  logic                   pop;
  logic [2:0]             committed;

  assign pop = out_valid && out_ready;

  // Words buffered or in flight after this cycle's pop; a read is safe only if a slot remains.
  assign committed = 3'(occ) + 3'(pending_q) - 3'(pop);

  assign fifo_read_enable = !reset && enable && !fifo_empty && (committed < 3'd2);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q <= 1'b0;
      count_q   <= '0;
    end else begin
      pending_q <= fifo_read_enable;
      if (pop) begin
        count_q <= count_q + COUNT_WIDTH'(1);
      end
    end
  end

  fifo_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clock    (clock),
    .reset    (reset),
    .push     (pending_q),
    .push_data(fifo_data_in),
    .pop      (pop),
    .occ      (occ),
    .head     (out_data)
  );

  assign out_valid  = (occ != '0);
  assign word_count = count_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model, scoreboard queue, per-cycle vectors and corner sequences.
module tb_fifo_stream_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        fifo_empty;
  logic [7:0]  fifo_data_in;
  logic        out_ready;
  logic        fifo_read_enable;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [15:0] word_count;
  logic        rd4;
  logic [7:0]  data4;
  logic        valid4;
  logic [3:0]  wc4;

  fifo_stream_reader #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .fifo_read_enable(fifo_read_enable),
    .fifo_empty      (fifo_empty),
    .fifo_data_in    (fifo_data_in),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .word_count      (word_count)
  );

  fifo_stream_reader #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut4 (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .fifo_read_enable(rd4),
    .fifo_empty      (fifo_empty),
    .fifo_data_in    (fifo_data_in),
    .out_data        (data4),
    .out_valid       (valid4),
    .out_ready       (out_ready),
    .word_count      (wc4)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       en;
    logic       rdy;
    logic       exp_rd;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_count;
  } vec_t;

  vec_t       tbl[6];
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         reads  = 0;
  int         pops   = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // Called just after a falling edge with inputs already set; returns at the next falling edge.
  task automatic cycle();
    logic       rd;
    logic [7:0] w;
    #1;
    rd = fifo_read_enable;
    if (!enable || fifo_empty) chk("no_read_when_gated", {31'b0, rd}, 0);
    if (prev_hold) begin
      chk("hold_valid", {31'b0, out_valid}, 1);
      chk("hold_data", {24'b0, out_data}, {24'b0, prev_data});
    end
    if (rd) reads++;
    if (out_valid && out_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {24'b0, out_data}, 32'hFFFF_FFFF);
      end else begin
        w = exp_q.pop_front();
        chk("stream_data", {24'b0, out_data}, {24'b0, w});
      end
    end
    prev_hold = out_valid && !out_ready;
    prev_data = out_data;
    @(posedge clock);
    #1;
    if (rd && fifo_q.size() > 0) fifo_data_in = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    @(negedge clock);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_in_budget", {31'b0, n < budget}, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    prev_hold  = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic done16;
    int   n;

    // Streaming 0x11,0x22,0x33 after reset with the FIFO already holding data.
    tbl[0] = '{en: 1'b1, rdy: 1'b1, exp_rd: 1'b1, exp_valid: 1'b0, exp_data: 8'h00, exp_count: 0};
    tbl[1] = '{en: 1'b1, rdy: 1'b1, exp_rd: 1'b1, exp_valid: 1'b0, exp_data: 8'h00, exp_count: 0};
    tbl[2] = '{en: 1'b1, rdy: 1'b1, exp_rd: 1'b1, exp_valid: 1'b1, exp_data: 8'h11, exp_count: 0};
    tbl[3] = '{en: 1'b1, rdy: 1'b1, exp_rd: 1'b0, exp_valid: 1'b1, exp_data: 8'h22, exp_count: 1};
    tbl[4] = '{en: 1'b1, rdy: 1'b1, exp_rd: 1'b0, exp_valid: 1'b1, exp_data: 8'h33, exp_count: 2};
    tbl[5] = '{en: 1'b1, rdy: 1'b1, exp_rd: 1'b0, exp_valid: 1'b0, exp_data: 8'h33, exp_count: 3};

    reset        = 1'b1;
    enable       = 1'b1;
    out_ready    = 1'b0;
    fifo_empty   = 1'b1;
    fifo_data_in = 8'h5A;
    load(8'h11);
    load(8'h22);
    load(8'h33);
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("reset_valid", {31'b0, out_valid}, 0);
    chk("reset_data", {24'b0, out_data}, 0);
    chk("reset_rd", {31'b0, fifo_read_enable}, 0);
    chk("reset_count", {16'b0, word_count}, 0);
    @(negedge clock);
    enable = 1'b0;
    reset  = 1'b0;
    repeat (3) cycle();
    chk("disabled_reads", reads, 0);
    chk("disabled_fifo_level", fifo_q.size(), 3);

    for (int i = 0; i < 6; i++) begin
      enable    = tbl[i].en;
      out_ready = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d_rd", i), {31'b0, fifo_read_enable}, {31'b0, tbl[i].exp_rd});
      chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) chk($sformatf("vec%0d_data", i), {24'b0, out_data},
                                {24'b0, tbl[i].exp_data});
      chk($sformatf("vec%0d_count", i), {16'b0, word_count}, tbl[i].exp_count);
      cycle();
    end

    // Backpressure: only two reads fit while the consumer stalls.
    reads = 0;
    for (int i = 0; i < 5; i++) load(8'hA0 + 8'(i));
    enable    = 1'b1;
    out_ready = 1'b0;
    repeat (6) cycle();
    chk("bp_reads", reads, 2);
    chk("bp_fifo_level", fifo_q.size(), 3);
    chk("bp_valid", {31'b0, out_valid}, 1);
    chk("bp_head", {24'b0, out_data}, 32'hA0);
    out_ready = 1'b1;
    drain(40);

    // Enable drops right after a read issues; that word still lands.
    reads = 0;
    for (int i = 0; i < 4; i++) load(8'hB0 + 8'(i));
    enable = 1'b1;
    cycle();
    enable = 1'b0;
    repeat (6) cycle();
    chk("gate_reads", reads, 1);
    chk("gate_valid_low", {31'b0, out_valid}, 0);
    chk("gate_remaining", exp_q.size(), 3);
    enable = 1'b1;
    drain(40);

    // Full drain of 64 words with random ready; narrow counter wraps at 16.
    do_reset();
    pops   = 0;
    done16 = 1'b0;
    for (int i = 0; i < 64; i++) load(8'(i));
    enable = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
      out_ready = 1'($urandom_range(0, 1));
      cycle();
      if (pops == 16 && !done16) begin
        chk("wrap4_at_16", {28'b0, wc4}, 0);
        chk("count_at_16", {16'b0, word_count}, 16);
        done16 = 1'b1;
      end
      n++;
    end
    chk("random_in_budget", {31'b0, n < 2000}, 1);
    chk("random_count", {16'b0, word_count}, 64);
    chk("random_wc4", {28'b0, wc4}, 0);
    chk("random_valid_end", {31'b0, out_valid}, 0);
    chk("random_valid4_end", {31'b0, valid4}, 0);

    // Asynchronous reset with a word buffered and another in flight.
    for (int i = 0; i < 4; i++) load(8'hD0 + 8'(i));
    enable    = 1'b1;
    out_ready = 1'b0;
    cycle();
    cycle();
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_valid", {31'b0, out_valid}, 0);
    chk("midreset_count", {16'b0, word_count}, 0);
    chk("midreset_data", {24'b0, out_data}, 0);
    chk("midreset_rd", {31'b0, fifo_read_enable}, 0);
    fifo_q.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    prev_hold  = 1'b0;
    @(negedge clock);
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle();
    chk("post_reset_idle", {31'b0, out_valid}, 0);
    for (int i = 0; i < 3; i++) load(8'hE0 + 8'(i));
    drain(30);
    chk("post_reset_count", {16'b0, word_count}, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
